// File: rtl/queue_sensor_frontend_if.sv
// Photocell-to-counter signal bundle for queue_sensor_frontend.
// master = gate/counter side, slave = the front-end itself.
interface queue_sensor_frontend_if;
  logic raw_a;
  logic raw_b;
  logic sensor_a;
  logic sensor_b;
  logic blocked_a;
  logic blocked_b;
  logic stuck_a;
  logic stuck_b;

  modport master (
    output raw_a, raw_b,
    input  sensor_a, sensor_b, blocked_a, blocked_b, stuck_a, stuck_b
  );

  modport slave (
    input  raw_a, raw_b,
    output sensor_a, sensor_b, blocked_a, blocked_b, stuck_a, stuck_b
  );
endinterface

// File: rtl/queue_sensor_frontend.sv
// Synchronize, debounce and serialize entry/exit photocell events into single-cycle pulses.
// Optional stuck-gate detection is built when STUCK_DETECT_EN is defined.
module queue_sensor_frontend #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned DEB_W        = 3,
  parameter int unsigned STUCK_CYCLES = 1024,
  parameter int unsigned STUCK_W      = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  queue_sensor_frontend_if.slave  bus
);

  if (DEB_CYCLES < 2 || (1 << DEB_W) <= DEB_CYCLES) begin : g_bad_deb
    $error("queue_sensor_frontend: need DEB_CYCLES >= 2 and 2**DEB_W > DEB_CYCLES");
  end
  if ((1 << STUCK_W) <= STUCK_CYCLES) begin : g_bad_stuck
    $error("queue_sensor_frontend: need 2**STUCK_W > STUCK_CYCLES");
  end

  localparam int unsigned NCH = 2;  // index 0 = gate A, 1 = gate B

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1_q, sync1_d;
  logic [NCH-1:0]   sync2_q, sync2_d;
  logic [NCH-1:0]   blocked_q, blocked_d;
  logic [DEB_W-1:0] deb_cnt_q [NCH];
  logic [DEB_W-1:0] deb_cnt_d [NCH];
  logic [NCH-1:0]   fall;
  logic [NCH-1:0]   event_x;
  logic             sensor_a_q, sensor_a_d;
  logic             sensor_b_q, sensor_b_d;
  logic             pending_b_q, pending_b_d;
  logic             b_req;

  assign raw = {bus.raw_b, bus.raw_a};

  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    blocked_d = blocked_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != blocked_q[i]) begin
        if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
          blocked_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
    fall = blocked_q & ~blocked_d;
  end

`ifdef STUCK_DETECT_EN
  localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

  logic [STUCK_W-1:0] stuck_cnt_q [NCH];
  logic [STUCK_W-1:0] stuck_cnt_d [NCH];
  logic [NCH-1:0]     stuck_q, stuck_d;

  // Counter only runs while blocked and clears on the falling edge, so stuck
  // is simply "counter has reached the limit".
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      stuck_cnt_d[i] = stuck_cnt_q[i];
      if (!blocked_q[i] || fall[i]) begin
        stuck_cnt_d[i] = '0;
      end else if (stuck_cnt_q[i] != STUCK_MAX) begin
        stuck_cnt_d[i] = stuck_cnt_q[i] + 1'b1;
      end
      stuck_d[i] = (stuck_cnt_d[i] == STUCK_MAX);
    end
    event_x = fall & ~stuck_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stuck_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        stuck_cnt_q[i] <= '0;
      end
    end else begin
      stuck_q <= stuck_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        stuck_cnt_q[i] <= stuck_cnt_d[i];
      end
    end
  end

  assign bus.stuck_a = stuck_q[0];
  assign bus.stuck_b = stuck_q[1];
`else
  assign event_x     = fall;
  assign bus.stuck_a = 1'b0;
  assign bus.stuck_b = 1'b0;
`endif

  // A always goes out immediately; a B event that collides with an A event
  // is held in pending_b and retried each cycle until A is idle.
  always_comb begin
    b_req       = event_x[1] | pending_b_q;
    sensor_a_d  = event_x[0];
    sensor_b_d  = b_req & ~event_x[0];
    pending_b_d = b_req & event_x[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      blocked_q   <= '0;
      sensor_a_q  <= 1'b0;
      sensor_b_q  <= 1'b0;
      pending_b_q <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      blocked_q   <= blocked_d;
      sensor_a_q  <= sensor_a_d;
      sensor_b_q  <= sensor_b_d;
      pending_b_q <= pending_b_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  assign bus.sensor_a  = sensor_a_q;
  assign bus.sensor_b  = sensor_b_q;
  assign bus.blocked_a = blocked_q[0];
  assign bus.blocked_b = blocked_q[1];

endmodule

// File: tb/tb_queue_sensor_frontend.sv
// Self-checking bench for queue_sensor_frontend against a history-based reference model.
module tb_queue_sensor_frontend;
  localparam int DEB = 4;
  localparam int STK = 16;
`ifdef STUCK_DETECT_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  queue_sensor_frontend_if bus ();

  queue_sensor_frontend #(
    .DEB_CYCLES  (DEB),
    .DEB_W       (3),
    .STUCK_CYCLES(STK),
    .STUCK_W     (5)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: raw samples taken at each edge since reset, debounced
  // level, time spent blocked, and a backlog of B pulses still owed.
  bit ha[$];
  bit hb[$];
  bit m_lvl[2];
  int m_age[2];
  bit m_stuck[2];
  int b_backlog;
  bit exp_sa, exp_sb;

  function automatic bit raw_at(int ch, int idx);
    if (idx < 0) return 1'b0;
    return (ch == 0) ? ha[idx] : hb[idx];
  endfunction

  task automatic model_edge(input bit r, input bit ra, input bit rb);
    bit ev[2];
    if (!r) begin
      ha.delete(); hb.delete();
      for (int c = 0; c < 2; c++) begin m_lvl[c] = 0; m_age[c] = 0; m_stuck[c] = 0; end
      b_backlog = 0; exp_sa = 0; exp_sb = 0;
      return;
    end
    ha.push_back(ra);
    hb.push_back(rb);
    for (int c = 0; c < 2; c++) begin
      int t;
      bit flip, old_l, new_l, was_stuck;
      t = ha.size() - 1;
      // level changes once the last DEB synchronized samples (raw from two edges earlier) all disagree
      flip = (t >= DEB - 1);
      for (int k = 0; k < DEB; k++)
        if (raw_at(c, t - k - 2) == m_lvl[c]) flip = 0;
      old_l = m_lvl[c];
      new_l = flip ? ~old_l : old_l;
      was_stuck = m_stuck[c];
      if (old_l) m_age[c]++;
      if (!new_l) m_age[c] = 0;
      ev[c] = old_l && !new_l && !(STUCK_EN && was_stuck);
      m_stuck[c] = STUCK_EN && new_l && (m_age[c] >= STK);
      m_lvl[c] = new_l;
    end
    if (ev[1]) b_backlog++;
    exp_sa = ev[0];
    exp_sb = 0;
    if (!ev[0] && b_backlog > 0) begin exp_sb = 1; b_backlog--; end
  endtask

  task automatic tick();
    bit r, ra, rb;
    r = rst_n; ra = bus.raw_a; rb = bus.raw_b;
    @(posedge clk);
    #1;
    model_edge(r, ra, rb);
  endtask

  function automatic logic [5:0] dut_out();
    return {bus.sensor_a, bus.sensor_b, bus.blocked_a, bus.blocked_b, bus.stuck_a, bus.stuck_b};
  endfunction

  function automatic logic [5:0] exp_out();
    return {exp_sa, exp_sb, m_lvl[0], m_lvl[1], m_stuck[0], m_stuck[1]};
  endfunction

  task automatic test_reset();
    bus.raw_a = 0; bus.raw_b = 0; rst_n = 0;
    tick(); tick();
    n_checks++;
    if (dut_out() !== 6'b0) $display("FAIL reset_state got=%b exp=%b", dut_out(), 6'b0);
    else n_pass++;
    rst_n = 1;
    for (int e = 0; e < 8; e++) begin
      tick();
      n_checks++;
      if (dut_out() !== exp_out()) $display("FAIL reset_idle e=%0d got=%b exp=%b", e, dut_out(), exp_out());
      else n_pass++;
    end
  endtask

  task automatic test_entry();
    int rise_e = -1, pulse_e = -1, pulses = 0, sb_seen = 0;
    bus.raw_a = 1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      n_checks++;
      if (dut_out() !== exp_out()) $display("FAIL entry_cycle e=%0d got=%b exp=%b", e, dut_out(), exp_out());
      else n_pass++;
      if (bus.blocked_a && rise_e < 0) rise_e = e;
      if (bus.sensor_a) begin pulses++; pulse_e = e; end
      if (bus.sensor_b) sb_seen++;
      if (e == 10) bus.raw_a = 0;
    end
    n_checks++;
    if (rise_e !== 6) $display("FAIL entry_blocked_edge got=%0d exp=6", rise_e); else n_pass++;
    n_checks++;
    if (pulse_e !== 16) $display("FAIL entry_pulse_edge got=%0d exp=16", pulse_e); else n_pass++;
    n_checks++;
    if (pulses !== 1) $display("FAIL entry_pulse_count got=%0d exp=1", pulses); else n_pass++;
    n_checks++;
    if (sb_seen !== 0) $display("FAIL entry_no_sensor_b got=%0d exp=0", sb_seen); else n_pass++;
  endtask

  task automatic test_glitch();
    int blk = 0, sb = 0;
    // 3-cycle glitch must be ignored, 4-cycle high must be accepted
    for (int len = 3; len <= 4; len++) begin
      blk = 0; sb = 0;
      bus.raw_b = 1;
      for (int e = 1; e <= 20; e++) begin
        tick();
        n_checks++;
        if (dut_out() !== exp_out()) $display("FAIL glitch_cycle len=%0d e=%0d got=%b exp=%b", len, e, dut_out(), exp_out());
        else n_pass++;
        if (bus.blocked_b) blk++;
        if (bus.sensor_b) sb++;
        if (e == len) bus.raw_b = 0;
      end
      n_checks++;
      if ((blk != 0) !== (len == 4)) $display("FAIL glitch_blocked len=%0d got=%0d exp_any=%0d", len, blk, len == 4);
      else n_pass++;
      n_checks++;
      if (sb !== ((len == 4) ? 1 : 0)) $display("FAIL glitch_pulse len=%0d got=%0d exp=%0d", len, sb, (len == 4) ? 1 : 0);
      else n_pass++;
    end
  endtask

  task automatic test_coincident();
    int sa_e = -1, sb_e = -1, both = 0;
    bus.raw_a = 1; bus.raw_b = 1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      n_checks++;
      if (dut_out() !== exp_out()) $display("FAIL coinc_cycle e=%0d got=%b exp=%b", e, dut_out(), exp_out());
      else n_pass++;
      if (bus.sensor_a) sa_e = e;
      if (bus.sensor_b) sb_e = e;
      if (bus.sensor_a && bus.sensor_b) both++;
      if (e == 10) begin bus.raw_a = 0; bus.raw_b = 0; end
    end
    n_checks++;
    if (sa_e !== 16) $display("FAIL coinc_a_edge got=%0d exp=16", sa_e); else n_pass++;
    n_checks++;
    if (sb_e !== 17) $display("FAIL coinc_b_edge got=%0d exp=17", sb_e); else n_pass++;
    n_checks++;
    if (both !== 0) $display("FAIL coinc_overlap got=%0d exp=0", both); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int sa = 0;
    bus.raw_a = 1;
    for (int e = 1; e <= 8; e++) tick();
    n_checks++;
    if (bus.blocked_a !== 1'b1) $display("FAIL rstmid_pre_blocked got=%b exp=1", bus.blocked_a); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (dut_out() !== 6'b0) $display("FAIL rstmid_async got=%b exp=%b", dut_out(), 6'b0); else n_pass++;
    for (int e = 0; e < 3; e++) begin
      tick();
      n_checks++;
      if (dut_out() !== 6'b0) $display("FAIL rstmid_held e=%0d got=%b exp=%b", e, dut_out(), 6'b0);
      else n_pass++;
    end
    rst_n = 1;
    tick();
    bus.raw_a = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_checks++;
      if (dut_out() !== exp_out()) $display("FAIL rstmid_cycle e=%0d got=%b exp=%b", e, dut_out(), exp_out());
      else n_pass++;
      if (bus.sensor_a) sa++;
    end
    n_checks++;
    if (sa !== 0) $display("FAIL rstmid_no_pulse got=%0d exp=0", sa); else n_pass++;
  endtask

  task automatic test_stuck();
    int blk_e = -1, stk_e = -1, clr_e = -1, sa = 0, stk_seen = 0;
    bus.raw_a = 1;
    for (int e = 1; e <= 60; e++) begin
      tick();
      n_checks++;
      if (dut_out() !== exp_out()) $display("FAIL stuck_cycle e=%0d got=%b exp=%b", e, dut_out(), exp_out());
      else n_pass++;
      if (bus.blocked_a && blk_e < 0) blk_e = e;
      if (bus.stuck_a) begin stk_seen++; if (stk_e < 0) stk_e = e; end
      if (stk_e > 0 && !bus.stuck_a && clr_e < 0) clr_e = e;
      if (bus.sensor_a) sa++;
      if (e == 40) bus.raw_a = 0;
    end
    if (STUCK_EN) begin
      n_checks++;
      if (stk_e !== blk_e + STK) $display("FAIL stuck_rise_edge got=%0d exp=%0d", stk_e, blk_e + STK); else n_pass++;
      n_checks++;
      if (clr_e !== 46) $display("FAIL stuck_clear_edge got=%0d exp=46", clr_e); else n_pass++;
      n_checks++;
      if (sa !== 0) $display("FAIL stuck_suppress got=%0d exp=0", sa); else n_pass++;
    end else begin
      n_checks++;
      if (stk_seen !== 0) $display("FAIL stuck_disabled got=%0d exp=0", stk_seen); else n_pass++;
      n_checks++;
      if (sa !== 1) $display("FAIL stuck_disabled_pulse got=%0d exp=1", sa); else n_pass++;
    end
  endtask

  task automatic test_random();
    int hold_a = 0, hold_b = 0, both = 0, rst_hold = 0;
    for (int e = 0; e < 1500; e++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1;
      end else if ($urandom_range(299) == 0) begin
        rst_n = 0; rst_hold = $urandom_range(3, 1);
      end
      if (hold_a == 0) begin
        bus.raw_a = $urandom_range(1);
        hold_a = $urandom_range(14, 1);
        if ($urandom_range(3) == 0) begin bus.raw_b = bus.raw_a; hold_b = hold_a; end
      end
      if (hold_b == 0) begin bus.raw_b = $urandom_range(1); hold_b = $urandom_range(14, 1); end
      hold_a--; hold_b--;
      tick();
      n_checks++;
      if (dut_out() !== exp_out()) $display("FAIL random_cycle e=%0d got=%b exp=%b", e, dut_out(), exp_out());
      else n_pass++;
      if (bus.sensor_a && bus.sensor_b) both++;
    end
    n_checks++;
    if (both !== 0) $display("FAIL random_overlap got=%0d exp=0", both); else n_pass++;
    rst_n = 1; bus.raw_a = 0; bus.raw_b = 0;
    for (int e = 0; e < 30; e++) tick();
  endtask

  initial begin
    bus.raw_a = 0;
    bus.raw_b = 0;
    test_reset();
    test_entry();
    for (int e = 0; e < 10; e++) tick();
    test_glitch();
    test_coincident();
    for (int e = 0; e < 10; e++) tick();
    test_reset_mid();
    test_stuck();
    for (int e = 0; e < 10; e++) tick();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/queue_sensor_frontend.md
Name: queue_sensor_frontend

Overview:
Front-end that produces the sensor_a / sensor_b event pulses consumed by the queue people-counter. It takes raw photocell beam-break levels from the entry gate (A) and exit gate (B) and synchronizes and debounces them. It emits exactly one single-cycle pulse per person, on the blocked->clear transition of each gate. It also serializes coincident A/B events so the counter never sees both pulses in the same cycle.

Parameters:
DEB_CYCLES, 4, consecutive synchronized samples needed to accept a level change; legal range >= 2
DEB_W, 3, width of each debounce counter; must satisfy 2^DEB_W > DEB_CYCLES
STUCK_CYCLES, 1024, debounced-blocked duration that flags a stuck gate (used only with the macro)
STUCK_W, 11, width of each stuck counter; must satisfy 2^STUCK_W > STUCK_CYCLES

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  asynchronous, active-low reset
raw_a  input  1  entry photocell; 1 = beam broken; asynchronous to clk
raw_b  input  1  exit photocell; 1 = beam broken; asynchronous to clk
sensor_a  output  1  one-cycle pulse, person entered; feeds the counter
sensor_b  output  1  one-cycle pulse, person left; feeds the counter
blocked_a  output  1  debounced level of gate A
blocked_b  output  1  debounced level of gate B
stuck_a  output  1  gate A blocked too long (macro only; otherwise constant 0)
stuck_b  output  1  gate B blocked too long (macro only; otherwise constant 0)

Behaviour:
- Reset (rst = 0, asynchronous): all synchronizer flops, debounce levels, counters, the pending flag, sensor_a/b, blocked_a/b and stuck_a/b go to 0 immediately. Reset mid-debounce discards partial counts. A person partly through a gate at reset produces no pulse.
- Synchronizer: two-flop synchronizer per channel; s_x is the second flop.
- Debounce, per channel, evaluated at each edge:
  - If s_x == blocked_x, the counter clears to 0.
  - Otherwise, if the counter == DEB_CYCLES-1, blocked_x <= s_x and the counter clears.
  - Otherwise the counter increments.
  - A glitch shorter than DEB_CYCLES samples never changes blocked_x.
- Event detection: event_x is true at the edge where blocked_x flips 1->0. A 0->1 flip produces no event.
- Latency: raw change is held stable from edge E0; blocked_x flips at edge E(DEB_CYCLES+2); the pulse is high for the cycle following that edge. With defaults, a rise of raw_a before E0 gives blocked_a high after E6. A fall before E10 gives sensor_a high after E16.
- Pulse width is always exactly 1 cycle. Outputs are registered.
- Coincidence (event_a and event_b at the same edge):
  - sensor_a pulses that cycle; pending_b is set.
  - sensor_b pulses the next cycle; pending_b then clears.
  - A never waits. No event is ever dropped.
- A pending B cannot collide with a new B event, because a B event requires at least 2*DEB_CYCLES cycles since the previous one.
- Whenever event_a and pending_b fall on the same edge, sensor_a and sensor_b are never both high in one cycle: sensor_a has priority and the B pulse slips one more cycle.
- Constant raw input: no pulses, and no counter overflow.

Optional Feature:
STUCK_DETECT_EN
- Defined:
  - A per-channel STUCK_W counter runs while blocked_x = 1 and saturates at STUCK_CYCLES.
  - stuck_x goes to 1 at the edge where the count reaches STUCK_CYCLES.
  - When blocked_x next falls, stuck_x clears at that edge and the event pulse is suppressed (the object is not a person); the counter clears.
  - Reset clears everything.
- Undefined: no stuck counters are built; stuck_a = stuck_b = 0; every blocked->clear produces a pulse.

Test Plan:
- Reset, then raw_a high for 10 cycles then low -> blocked_a high after edge 6; a single sensor_a pulse after edge 16; sensor_b never high.
- raw_b glitch high for 3 cycles (DEB_CYCLES = 4) -> blocked_b stays 0; no sensor_b pulse.
- raw_a and raw_b toggled on identical cycles (high 10, low) -> sensor_a pulses cycle N, sensor_b pulses cycle N+1; they are never high together.
- rst low in the middle of a raw_a blocked window, released, then raw_a low -> all outputs 0 during reset; no sensor_a pulse for that passage.
- STUCK_DETECT_EN with STUCK_CYCLES = 16: raw_a held high 40 cycles then low -> stuck_a rises 16 cycles after blocked_a; it clears when blocked_a falls, with no sensor_a pulse. Without the macro: sensor_a pulses and stuck_a stays 0.
